fpga_cfg_loader: RTL
====================

# fpga_cfg_loader

Configuration loader that sits directly upstream of the FPGA fabric's configuration flip-flop chain. It accepts bitstream bytes over a valid/ready byte interface and serialises them MSB-first onto `ccff_head`. For every bit it issues a one-cycle shift enable that gates the chain's programming clock. It counts bits up to the chain length, flags completion or timeout, and accumulates the XOR parity of the old configuration bits that emerge on `ccff_tail` as readback.

## Interface
Parameters:
- `CHAIN_LEN`, default 1024: number of configuration bits in the chain; must be ≥ 1.
- `TIMEOUT`, default 4096: maximum number of `clk` cycles allowed in LOAD while waiting for a byte; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; every register is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load.
- `byte_in`  in  8  bitstream byte; the MSB is shifted first.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader can accept a byte.
- `ccff_head`  out  1  serial data into the configuration chain.
- `prog_shift`  out  1  one-cycle enable; the chain shifts on the `clk` edge at which this is high.
- `ccff_tail`  in  1  serial output of the configuration chain.
- `cfg_busy`  out  1  high in LOAD and SHIFT.
- `cfg_done`  out  1  exactly `CHAIN_LEN` bits have been shifted.
- `cfg_err`  out  1  byte timeout occurred.
- `readback_parity`  out  1  XOR of all `ccff_tail` samples taken during the current load.

## Operation
- Internal state: 8-bit shift register `sr`, 3-bit in-byte counter, bit counter of width clog2(`CHAIN_LEN`+1), timeout counter of width clog2(`TIMEOUT`+1).
- FSM states are IDLE, LOAD, SHIFT, DONE and ERR.
- IDLE:
  - `start` → LOAD.
  - On entry to LOAD, the bit counter, timeout counter and `readback_parity` are cleared, and `cfg_done` and `cfg_err` are cleared.
- LOAD:
  - `byte_ready` = 1.
  - Handshake is `byte_valid & byte_ready`. On handshake: `sr <= byte_in`, in-byte counter cleared, → SHIFT.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT` → ERR.
- SHIFT:
  - Each cycle: `prog_shift` = 1, `ccff_head` = `sr[7]`.
  - On that edge: `sr <= {sr[6:0],1'b0}`, bit counter +1, `readback_parity <= readback_parity ^ ccff_tail`.
  - The new bit count reaching `CHAIN_LEN` → DONE. This takes priority, so a final partial byte shifts only its top `CHAIN_LEN mod 8` bits and the remaining bits are discarded.
  - Otherwise, after the 8th bit → LOAD, with the timeout counter cleared.
- DONE: `cfg_done` = 1 and stays high. `start` → LOAD, which is a full reload.
- ERR: `cfg_err` = 1 and stays high. `start` → LOAD, which clears the error.
- `start` in LOAD or SHIFT is ignored.
- `byte_valid` outside LOAD is ignored; `byte_ready` is 0 there, so no byte is consumed.
- `cfg_busy` = 1 exactly in LOAD and SHIFT.
- `ccff_head` = 0 whenever `prog_shift` = 0.

## Timing
- Reset, synchronous and dominant over all other inputs:
  - State → IDLE.
  - `byte_ready`, `ccff_head`, `prog_shift`, `cfg_busy`, `cfg_done`, `cfg_err`, `readback_parity` all = 0.
  - Counters = 0.
- Reset mid-SHIFT: from the next cycle, `prog_shift` = 0 with no partial-byte completion; the chain holds whatever bits had already been shifted.
- `byte_ready`, `prog_shift`, `ccff_head` and the status outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.
- Latency from `start` at edge N: LOAD and `byte_ready` = 1 in cycle N+1.
- Byte timing for a byte accepted at edge M:
  - `prog_shift` is high for cycles M+1 … M+8.
  - `byte_ready` returns in cycle M+9.
  - Peak throughput is one byte per 9 cycles.
- Completion: `cfg_done` rises in the cycle after the edge that shifts bit `CHAIN_LEN`. `cfg_busy` falls in the same cycle.
- Timeout: ERR is entered on the edge at which the LOAD wait count reaches `TIMEOUT`. `cfg_err` is high in the following cycle.
- Parity sampling: `ccff_tail` is sampled only on edges where `prog_shift` = 1. That is `CHAIN_LEN` samples per complete load.

## Test plan
- Full 16-bit load (`CHAIN_LEN`=16): `start`, then bytes 0xA5 and 0x3C with `byte_valid` held high.
  - `ccff_head` during the `prog_shift` cycles must be 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - `cfg_done`=1 18 cycles after the first handshake edge, and `cfg_busy`=0 from then on.
- Partial final byte (`CHAIN_LEN`=12): bytes 0xFF and 0xF0.
  - Exactly 12 `prog_shift` pulses, last four `ccff_head` = 1; DONE reached with no 13th pulse.
  - A third byte offered stays unconsumed (`byte_ready`=0).
- Readback parity (`CHAIN_LEN`=16): tie `ccff_tail` to a model chain preloaded with 0x0001 → `readback_parity`=1 at DONE. A second load of the same chain contents gives the expected parity.
- Timeout (`TIMEOUT`=5): `start`, no `byte_valid`.
  - `cfg_err`=1 6 cycles after `start`, `cfg_busy`=0.
  - `start` clears `cfg_err` and returns to LOAD.
- Backpressure and ignored inputs:
  - `byte_valid` held during SHIFT: next byte accepted only at the first LOAD cycle.
  - `start` pulsed mid-SHIFT: no effect on the bit count.
- Reset mid-SHIFT after 3 bits: the next cycle shows `prog_shift`=0 and all outputs 0. A fresh `start` plus a full load completes with the correct pulse count.

Source files
------------

// File: rtl/fpga_cfg_loader.sv
// Bitstream loader for the fabric configuration chain: takes bytes over a
// valid/ready interface and shifts them MSB-first into ccff_head.
module fpga_cfg_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       ccff_head,
  output logic       prog_shift,
  input  logic       ccff_tail,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic       readback_parity
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LP_LEN = BW'(CHAIN_LEN);
  localparam logic [TW-1:0] LP_TMO = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE,
    ERR
  } state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [7:0]     r_sr;
  logic [2:0]     r_byteCnt;
  logic [BW-1:0]  r_bitCnt;
  logic [TW-1:0]  r_tmoCnt;
  logic           r_parity;

  logic [BW-1:0]  w_bitNext;
  logic [TW-1:0]  w_tmoNext;
  logic           w_lastBit;
  logic           w_timeout;

  assign w_bitNext = r_bitCnt + BW'(1);
  assign w_tmoNext = r_tmoCnt + TW'(1);
  assign w_lastBit = (w_bitNext == LP_LEN);
  assign w_timeout = (w_tmoNext == LP_TMO);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Outputs depend only on r_state and registers, never directly on inputs.
  always_comb begin
    w_nextState = r_state;
    byte_ready  = 1'b0;
    prog_shift  = 1'b0;
    ccff_head   = 1'b0;
    cfg_busy    = 1'b0;
    cfg_done    = 1'b0;
    cfg_err     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_nextState = LOAD;
      end
      LOAD: begin
        byte_ready = 1'b1;
        cfg_busy   = 1'b1;
        if (byte_valid)     w_nextState = SHIFT;
        else if (w_timeout) w_nextState = ERR;
      end
      SHIFT: begin
        prog_shift = 1'b1;
        ccff_head  = r_sr[7];
        cfg_busy   = 1'b1;
        if (w_lastBit)              w_nextState = DONE;
        else if (r_byteCnt == 3'd7) w_nextState = LOAD;
      end
      DONE: begin
        cfg_done = 1'b1;
        if (start) w_nextState = LOAD;
      end
      ERR: begin
        cfg_err = 1'b1;
        if (start) w_nextState = LOAD;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath; the chain shifts on every edge where r_state is SHIFT, so the
  // tail sample and the bit count advance in lockstep with prog_shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr      <= '0;
      r_byteCnt <= '0;
      r_bitCnt  <= '0;
      r_tmoCnt  <= '0;
      r_parity  <= 1'b0;
    end else begin
      unique case (r_state)
        LOAD: begin
          if (byte_valid) begin
            r_sr      <= byte_in;
            r_byteCnt <= '0;
          end else begin
            r_tmoCnt  <= w_tmoNext;
          end
        end
        SHIFT: begin
          r_sr      <= {r_sr[6:0], 1'b0};
          r_bitCnt  <= w_bitNext;
          r_byteCnt <= r_byteCnt + 3'd1;
          r_parity  <= r_parity ^ ccff_tail;
          if (r_byteCnt == 3'd7) r_tmoCnt <= '0;
        end
        default: begin
          if (start) begin
            r_bitCnt <= '0;
            r_tmoCnt <= '0;
            r_parity <= 1'b0;
          end
        end
      endcase
    end
  end

  assign readback_parity = r_parity;

endmodule
